// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared encodings for the MIPS-subset control path.
//             Contents: opcode and funct constants, PC-source select codes,
//             and the run-state enumeration.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Opcodes, taken from instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  // R-format funct codes; these double as ALU operation codes
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  // PC source select
  localparam logic [1:0] PC_PLUS1  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Run-state machine
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_decoder
//  Purpose  : Purely combinational instruction decode table. It produces raw,
//             ungated enables. The parent module qualifies those enables with
//             the run state.
//  Ports    : opcode, funct, out_alu   -> instruction fields and ALU result
//             is_R/I/J_type            -> instruction format flags
//             is_write_from_mem        -> write-back source is memory
//             dec_write_reg/mem        -> ungated register / memory writes
//             dec_load_pc              -> ungated PC update
//             control_mux_for_PC       -> PC source select
//             opcode_alu               -> ALU function (MIPS funct encoding)
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_decoder
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 6
) (
  input  logic [OPW-1:0]   opcode,
  input  logic [OPW-1:0]   funct,
  input  logic [WIDTH-1:0] out_alu,
  output logic             is_R_type,
  output logic             is_I_type,
  output logic             is_J_type,
  output logic             is_write_from_mem,
  output logic             dec_write_reg,
  output logic             dec_write_mem,
  output logic             dec_load_pc,
  output logic [1:0]       control_mux_for_PC,
  output logic [OPW-1:0]   opcode_alu
);

  logic w_alu_zero;

  assign w_alu_zero = (out_alu == '0);

  always_comb begin
    is_R_type          = 1'b0;
    is_I_type          = 1'b0;
    is_J_type          = 1'b0;
    is_write_from_mem  = 1'b0;
    dec_write_reg      = 1'b0;
    dec_write_mem      = 1'b0;
    // Undefined opcodes still advance the PC, so they behave as NOPs.
    dec_load_pc        = 1'b1;
    control_mux_for_PC = PC_PLUS1;
    opcode_alu         = '0;

    case (opcode)
      OP_RTYPE: begin
        is_R_type = 1'b1;
        case (funct)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT: begin
            opcode_alu    = funct;
            dec_write_reg = 1'b1;
          end
          // An unsupported funct becomes a harmless ADD with no write-back.
          default: opcode_alu = OPW'(F_ADD);
        endcase
      end
      OP_ADDI: begin
        is_I_type     = 1'b1;
        dec_write_reg = 1'b1;
        opcode_alu    = OPW'(F_ADD);
      end
      OP_LW: begin
        is_I_type         = 1'b1;
        dec_write_reg     = 1'b1;
        is_write_from_mem = 1'b1;
        opcode_alu        = OPW'(F_ADD);
      end
      OP_SW: begin
        is_I_type     = 1'b1;
        dec_write_mem = 1'b1;
        opcode_alu    = OPW'(F_ADD);
      end
      OP_BEQ: begin
        is_I_type  = 1'b1;
        opcode_alu = OPW'(F_SUB);
        if (w_alu_zero) control_mux_for_PC = PC_BRANCH;
      end
      OP_BNE: begin
        is_I_type  = 1'b1;
        opcode_alu = OPW'(F_SUB);
        if (!w_alu_zero) control_mux_for_PC = PC_BRANCH;
      end
      OP_J: begin
        is_J_type          = 1'b1;
        control_mux_for_PC = PC_JUMP;
        opcode_alu         = OPW'(F_ADD);
      end
      OP_HALT: begin
        dec_load_pc = 1'b0;
        opcode_alu  = OPW'(F_ADD);
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_control_unit
//  Purpose  : Control path of the single-cycle MIPS-subset CPU. It combines
//             the decode table with the IDLE/RUN/HALT run-state machine, and
//             gates every state-changing enable with that state.
//  Ports    : clk, rst (async, active-low)
//             opcode, funct, out_alu        -> from the data path
//             type flags, write enables, PC select, ALU code -> to data path
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPW-1:0]   opcode,
  input  logic [OPW-1:0]   funct,
  input  logic [WIDTH-1:0] out_alu,
  output logic             is_R_type,
  output logic             is_I_type,
  output logic             is_J_type,
  output logic             is_write_from_mem,
  output logic             is_write_reg,
  output logic             is_write_mem,
  output logic             is_load_PC,
  output logic [1:0]       control_mux_for_PC,
  output logic [OPW-1:0]   opcode_alu
);

  state_t r_state;
  state_t w_state_next;
  logic   w_run;
  logic   w_dec_write_reg;
  logic   w_dec_write_mem;
  logic   w_dec_load_pc;

  cpu_decoder #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_decoder (
    .opcode             (opcode),
    .funct              (funct),
    .out_alu            (out_alu),
    .is_R_type          (is_R_type),
    .is_I_type          (is_I_type),
    .is_J_type          (is_J_type),
    .is_write_from_mem  (is_write_from_mem),
    .dec_write_reg      (w_dec_write_reg),
    .dec_write_mem      (w_dec_write_mem),
    .dec_load_pc        (w_dec_load_pc),
    .control_mux_for_PC (control_mux_for_PC),
    .opcode_alu         (opcode_alu)
  );

  // State register. Asserting reset forces IDLE at once, which drops every
  // enable before the next edge, so an in-flight write is never committed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state logic. IDLE lasts exactly one edge, which gives the data path
  // a settle cycle after reset before anything is written.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: w_state_next = ST_RUN;
      ST_RUN:  if (opcode == OPW'(OP_HALT)) w_state_next = ST_HALT;
      ST_HALT: w_state_next = ST_HALT;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output logic: only RUN lets the decoded enables through.
  always_comb begin
    w_run = 1'b0;
    if (r_state == ST_RUN) w_run = 1'b1;
  end

  assign is_write_reg = w_run & w_dec_write_reg;
  assign is_write_mem = w_run & w_dec_write_mem;
  assign is_load_PC   = w_run & w_dec_load_pc;

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_control_unit
//  Purpose  : Self-checking bench for cpu_control_unit. Directed scenarios
//             and randomized traffic are compared against a behavioural
//             model of the decode table and run state.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  opcode = 6'h00;
  logic [5:0]  funct = 6'h20;
  logic [31:0] out_alu = 32'h0;
  logic        is_R_type, is_I_type, is_J_type, is_write_from_mem;
  logic        is_write_reg, is_write_mem, is_load_PC;
  logic [1:0]  control_mux_for_PC;
  logic [5:0]  opcode_alu;

  cpu_control_unit #(.WIDTH(32), .OPW(6)) dut (
    .clk                (clk),
    .rst                (rst),
    .opcode             (opcode),
    .funct              (funct),
    .out_alu            (out_alu),
    .is_R_type          (is_R_type),
    .is_I_type          (is_I_type),
    .is_J_type          (is_J_type),
    .is_write_from_mem  (is_write_from_mem),
    .is_write_reg       (is_write_reg),
    .is_write_mem       (is_write_mem),
    .is_load_PC         (is_load_PC),
    .control_mux_for_PC (control_mux_for_PC),
    .opcode_alu         (opcode_alu)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed vector: R I J wfm wreg wmem loadpc mux[1:0] alu[5:0]
  logic [14:0] obs;
  assign obs = {is_R_type, is_I_type, is_J_type, is_write_from_mem,
                is_write_reg, is_write_mem, is_load_PC,
                control_mux_for_PC, opcode_alu};

  // Run model: count the edges since reset release and remember whether a
  // HALT was executed while running.
  int m_edges  = 0;
  bit m_halted = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_edges  <= 0;
      m_halted <= 1'b0;
    end else begin
      if (m_edges >= 1 && !m_halted && opcode == 6'h3F) m_halted <= 1'b1;
      if (m_edges < 1000) m_edges <= m_edges + 1;
    end
  end

  function automatic logic m_run();
    return rst && (m_edges >= 1) && !m_halted;
  endfunction

  function automatic logic [14:0] expect_vec(input logic [5:0] op, input logic [5:0] fn,
                                             input logic [31:0] a, input logic run);
    logic r, i, j, wfm, wr, wm, lp;
    logic [1:0] mux;
    logic [5:0] alu;
    r = 0; i = 0; j = 0; wfm = 0; wr = 0; wm = 0; mux = 2'b00; alu = 6'h00;
    lp = (op != 6'h3F);
    case (op)
      6'h00: begin
        r = 1;
        if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A) begin
          alu = fn; wr = 1;
        end else alu = 6'h20;
      end
      6'h08: begin i = 1; wr = 1; alu = 6'h20; end
      6'h23: begin i = 1; wr = 1; wfm = 1; alu = 6'h20; end
      6'h2B: begin i = 1; wm = 1; alu = 6'h20; end
      6'h04: begin i = 1; alu = 6'h22; mux = (a == 0) ? 2'b01 : 2'b00; end
      6'h05: begin i = 1; alu = 6'h22; mux = (a != 0) ? 2'b01 : 2'b00; end
      6'h02: begin j = 1; alu = 6'h20; mux = 2'b10; end
      6'h3F: alu = 6'h20;
      default: ;
    endcase
    return {r, i, j, wfm, wr & run, wm & run, lp & run, mux, alu};
  endfunction

  // Apply one instruction during the low phase; the sample point is 1 ns later.
  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a);
    @(negedge clk);
    opcode = op; funct = fn; out_alu = a;
    #1;
  endtask

  task automatic test_reset();
    logic [14:0] exp;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(6'h00, 6'h20, 32'h0);
      checks++;
      if (is_write_reg !== 1'b0 || is_load_PC !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: wreg=%b loadpc=%b expected 0 0", is_write_reg, is_load_PC);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (is_write_reg !== 1'b0 || is_load_PC !== 1'b0) begin
      errors++;
      $display("FAIL reset_settle: wreg=%b loadpc=%b expected 0 0", is_write_reg, is_load_PC);
    end
    drive(6'h00, 6'h20, 32'h0);
    checks++;
    if (is_write_reg !== 1'b1 || is_load_PC !== 1'b1) begin
      errors++;
      $display("FAIL reset_run: wreg=%b loadpc=%b expected 1 1", is_write_reg, is_load_PC);
    end
    exp = expect_vec(opcode, funct, out_alu, m_run());
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_vec: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fl [5];
    logic [14:0] exp;
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    drive(6'h00, 6'h22, 32'h5);
    checks++;
    if (is_R_type !== 1'b1 || opcode_alu !== 6'h22 || is_write_reg !== 1'b1) begin
      errors++;
      $display("FAIL rtype_sub: R=%b alu=%h wreg=%b expected 1 22 1", is_R_type, opcode_alu, is_write_reg);
    end
    for (int k = 0; k < 5; k++) begin
      drive(6'h00, fl[k], $urandom);
      exp = expect_vec(opcode, funct, out_alu, m_run());
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rtype_funct_%h: got %h expected %h", fl[k], obs, exp);
      end
    end
  endtask

  task automatic test_itype();
    logic [14:0] exp;
    drive(6'h23, $urandom, $urandom);
    checks++;
    if (is_I_type !== 1'b1 || is_write_from_mem !== 1'b1 || opcode_alu !== 6'h20 || is_write_reg !== 1'b1) begin
      errors++;
      $display("FAIL lw: I=%b wfm=%b alu=%h wreg=%b expected 1 1 20 1", is_I_type, is_write_from_mem, opcode_alu, is_write_reg);
    end
    drive(6'h2B, $urandom, $urandom);
    checks++;
    if (is_write_mem !== 1'b1 || is_write_reg !== 1'b0) begin
      errors++;
      $display("FAIL sw: wmem=%b wreg=%b expected 1 0", is_write_mem, is_write_reg);
    end
    drive(6'h08, $urandom, $urandom);
    exp = expect_vec(opcode, funct, out_alu, m_run());
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL addi: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_branch();
    drive(6'h04, 6'h00, 32'h0);
    checks++;
    if (control_mux_for_PC !== 2'b01 || opcode_alu !== 6'h22) begin
      errors++;
      $display("FAIL beq_taken: mux=%b alu=%h expected 01 22", control_mux_for_PC, opcode_alu);
    end
    drive(6'h04, 6'h00, 32'h5);
    checks++;
    if (control_mux_for_PC !== 2'b00) begin
      errors++;
      $display("FAIL beq_not_taken: mux=%b expected 00", control_mux_for_PC);
    end
    drive(6'h05, 6'h00, 32'h5);
    checks++;
    if (control_mux_for_PC !== 2'b01) begin
      errors++;
      $display("FAIL bne_taken: mux=%b expected 01", control_mux_for_PC);
    end
    drive(6'h05, 6'h00, 32'h0);
    checks++;
    if (control_mux_for_PC !== 2'b00) begin
      errors++;
      $display("FAIL bne_not_taken: mux=%b expected 00", control_mux_for_PC);
    end
    drive(6'h05, 6'h00, 32'h8000_0000);
    checks++;
    if (control_mux_for_PC !== 2'b01) begin
      errors++;
      $display("FAIL bne_msb: mux=%b expected 01", control_mux_for_PC);
    end
  endtask

  task automatic test_jump();
    drive(6'h02, $urandom, $urandom);
    checks++;
    if (is_J_type !== 1'b1 || control_mux_for_PC !== 2'b10 || is_write_reg !== 1'b0 ||
        is_write_mem !== 1'b0 || is_load_PC !== 1'b1) begin
      errors++;
      $display("FAIL jump: J=%b mux=%b wreg=%b wmem=%b loadpc=%b expected 1 10 0 0 1",
               is_J_type, control_mux_for_PC, is_write_reg, is_write_mem, is_load_PC);
    end
  endtask

  task automatic test_undefined();
    drive(6'h11, $urandom, $urandom);
    checks++;
    if ({is_R_type, is_I_type, is_J_type, is_write_from_mem, is_write_reg, is_write_mem} !== 6'b0 ||
        is_load_PC !== 1'b1 || control_mux_for_PC !== 2'b00) begin
      errors++;
      $display("FAIL undef_opcode: flags=%b loadpc=%b mux=%b expected 000000 1 00",
               {is_R_type, is_I_type, is_J_type, is_write_from_mem, is_write_reg, is_write_mem},
               is_load_PC, control_mux_for_PC);
    end
    drive(6'h00, 6'h07, 32'h0);
    checks++;
    if (is_write_reg !== 1'b0 || opcode_alu !== 6'h20 || is_load_PC !== 1'b1) begin
      errors++;
      $display("FAIL undef_funct: wreg=%b alu=%h loadpc=%b expected 0 20 1", is_write_reg, opcode_alu, is_load_PC);
    end
  endtask

  task automatic test_reset_midrun();
    drive(6'h2B, 6'h00, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (is_write_mem !== 1'b0 || is_load_PC !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: wmem=%b loadpc=%b expected 0 0", is_write_mem, is_load_PC);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(6'h2B, 6'h00, 32'h0);
    checks++;
    if (is_write_mem !== 1'b1) begin
      errors++;
      $display("FAIL reset_recover: wmem=%b expected 1", is_write_mem);
    end
  endtask

  task automatic test_halt();
    drive(6'h3F, 6'h00, 32'h0);
    checks++;
    if (is_load_PC !== 1'b0 || {is_R_type, is_I_type, is_J_type} !== 3'b000 || opcode_alu !== 6'h20) begin
      errors++;
      $display("FAIL halt_decode: loadpc=%b types=%b alu=%h expected 0 000 20",
               is_load_PC, {is_R_type, is_I_type, is_J_type}, opcode_alu);
    end
    drive(6'h08, 6'h00, 32'h0);
    checks++;
    if (is_load_PC !== 1'b0 || is_write_reg !== 1'b0 || is_write_mem !== 1'b0 || is_I_type !== 1'b1) begin
      errors++;
      $display("FAIL halt_hold_addi: loadpc=%b wreg=%b wmem=%b I=%b expected 0 0 0 1",
               is_load_PC, is_write_reg, is_write_mem, is_I_type);
    end
    drive(6'h2B, 6'h00, 32'h0);
    checks++;
    if (is_write_mem !== 1'b0 || is_load_PC !== 1'b0) begin
      errors++;
      $display("FAIL halt_hold_sw: wmem=%b loadpc=%b expected 0 0", is_write_mem, is_load_PC);
    end
    @(negedge clk);
    opcode = 6'h08;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (is_load_PC !== 1'b0 || is_write_reg !== 1'b0) begin
      errors++;
      $display("FAIL halt_restart_idle: loadpc=%b wreg=%b expected 0 0", is_load_PC, is_write_reg);
    end
    drive(6'h08, 6'h00, 32'h0);
    checks++;
    if (is_load_PC !== 1'b1 || is_write_reg !== 1'b1) begin
      errors++;
      $display("FAIL halt_restart_run: loadpc=%b wreg=%b expected 1 1", is_load_PC, is_write_reg);
    end
  endtask

  task automatic test_random();
    logic [5:0]  ops [8];
    logic [5:0]  fns [5];
    logic [5:0]  op, fn;
    logic [31:0] a;
    logic [14:0] exp;
    ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h11};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    for (int n = 0; n < 300; n++) begin
      if (m_halted && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({is_write_reg, is_write_mem, is_load_PC} !== 3'b000) begin
          errors++;
          $display("FAIL rand_reset: enables=%b expected 000", {is_write_reg, is_write_mem, is_load_PC});
        end
        #1;
        rst = 1'b1;
      end
      if ($urandom_range(0, 24) == 0) op = 6'h3F;
      else if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 7)];
      fn = $urandom_range(0, 1) ? fns[$urandom_range(0, 4)] : 6'($urandom);
      a  = $urandom_range(0, 1) ? 32'h0 : $urandom;
      drive(op, fn, a);
      exp = expect_vec(op, fn, a, m_run());
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rand_%0d op=%h fn=%h alu_in=%h: got %h expected %h", n, op, fn, a, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_branch();
    test_jump();
    test_undefined();
    test_reset_midrun();
    test_halt();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
